// File: rtl/reorder_buffer_if.sv
// Bus bundle between the reorder buffer and its neighbours (decoder, RS/LSB writeback, RegFile).
// The master modport is the surrounding pipeline; the slave modport is the reorder buffer.
interface reorder_buffer_if #(
    parameter int ROB_W = 4
);
    logic             full;
    logic             issue;
    logic [1:0]       issue_type;
    logic [4:0]       issue_rd;
    logic [31:0]      issue_pc;
    logic             issue_pred_jump;
    logic             issue_rdy;
    logic [31:0]      issue_val;
    logic [ROB_W-1:0] tail_pos;

    logic             alu_valid;
    logic [ROB_W-1:0] alu_pos;
    logic [31:0]      alu_val;
    logic             alu_jump;
    logic [31:0]      alu_target;
    logic             lsb_valid;
    logic [ROB_W-1:0] lsb_pos;
    logic [31:0]      lsb_val;

    logic [ROB_W-1:0] q1_pos;
    logic [ROB_W-1:0] q2_pos;
    logic             q1_rdy;
    logic             q2_rdy;
    logic [31:0]      q1_val;
    logic [31:0]      q2_val;

    logic             commit;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_val;
    logic [ROB_W-1:0] commit_pos;
    logic             store_commit;
    logic [ROB_W-1:0] store_pos;
    logic             rollback;
    logic [31:0]      rollback_pc;

    modport master (
        input  full, tail_pos, q1_rdy, q2_rdy, q1_val, q2_val,
        input  commit, commit_rd, commit_val, commit_pos,
        input  store_commit, store_pos, rollback, rollback_pc,
        output issue, issue_type, issue_rd, issue_pc, issue_pred_jump, issue_rdy, issue_val,
        output alu_valid, alu_pos, alu_val, alu_jump, alu_target,
        output lsb_valid, lsb_pos, lsb_val, q1_pos, q2_pos
    );

    modport slave (
        output full, tail_pos, q1_rdy, q2_rdy, q1_val, q2_val,
        output commit, commit_rd, commit_val, commit_pos,
        output store_commit, store_pos, rollback, rollback_pc,
        input  issue, issue_type, issue_rd, issue_pc, issue_pred_jump, issue_rdy, issue_val,
        input  alu_valid, alu_pos, alu_val, alu_jump, alu_target,
        input  lsb_valid, lsb_pos, lsb_val, q1_pos, q2_pos
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, capture two writeback buses, retire one head per cycle.
// Define ROB_WB_FWD_EN to forward same-cycle writeback values onto the operand queries.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             rdy,
    reorder_buffer_if.slave rob
);
    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    logic [ROB_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]   count_q, count_d;

    logic             busy_q   [ROB_SIZE];
    logic             busy_d   [ROB_SIZE];
    logic             ready_q  [ROB_SIZE];
    logic             ready_d  [ROB_SIZE];
    logic [1:0]       type_q   [ROB_SIZE];
    logic [1:0]       type_d   [ROB_SIZE];
    logic [4:0]       rd_q     [ROB_SIZE];
    logic [4:0]       rd_d     [ROB_SIZE];
    logic [31:0]      val_q    [ROB_SIZE];
    logic [31:0]      val_d    [ROB_SIZE];
    logic [31:0]      pc_q     [ROB_SIZE];
    logic [31:0]      pc_d     [ROB_SIZE];
    logic             pred_q   [ROB_SIZE];
    logic             pred_d   [ROB_SIZE];
    logic             jump_q   [ROB_SIZE];
    logic             jump_d   [ROB_SIZE];
    logic [31:0]      target_q [ROB_SIZE];
    logic [31:0]      target_d [ROB_SIZE];

    logic             commit_q, commit_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_val_q, commit_val_d;
    logic [ROB_W-1:0] commit_pos_q, commit_pos_d;
    logic             store_commit_q, store_commit_d;
    logic [ROB_W-1:0] store_pos_q, store_pos_d;
    logic             rollback_q, rollback_d;
    logic [31:0]      rollback_pc_q, rollback_pc_d;

    logic             head_fire;
    logic [31:0]      head_link;
    logic             q1_rdy, q2_rdy;
    logic [31:0]      q1_val, q2_val;

    assign head_link = pc_q[head_q] + 32'd4;

    // A pending rollback wins over everything else; otherwise writeback, retire and allocate combine.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        type_d         = type_q;
        rd_d           = rd_q;
        val_d          = val_q;
        pc_d           = pc_q;
        pred_d         = pred_q;
        jump_d         = jump_q;
        target_d       = target_q;
        commit_d       = commit_q;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_pos_d   = commit_pos_q;
        store_commit_d = store_commit_q;
        store_pos_d    = store_pos_q;
        rollback_d     = rollback_q;
        rollback_pc_d  = rollback_pc_q;
        head_fire      = 1'b0;
        if (rdy) begin
            commit_d       = 1'b0;
            store_commit_d = 1'b0;
            rollback_d     = 1'b0;
            if (rollback_q) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
            end else begin
                if (rob.alu_valid) begin
                    ready_d[rob.alu_pos]  = 1'b1;
                    val_d[rob.alu_pos]    = rob.alu_val;
                    jump_d[rob.alu_pos]   = rob.alu_jump;
                    target_d[rob.alu_pos] = rob.alu_target;
                end
                if (rob.lsb_valid) begin
                    ready_d[rob.lsb_pos] = 1'b1;
                    val_d[rob.lsb_pos]   = rob.lsb_val;
                end
                // Retirement looks only at registered readiness, so a same-cycle writeback waits a cycle.
                head_fire = busy_q[head_q] && ready_q[head_q];
                if (head_fire) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = head_q + ROB_W'(1);
                    case (type_q[head_q])
                        TYPE_STORE: begin
                            store_commit_d = 1'b1;
                            store_pos_d    = head_q;
                        end
                        TYPE_BRANCH: begin
                            commit_d      = 1'b1;
                            commit_rd_d   = rd_q[head_q];
                            commit_val_d  = head_link;
                            commit_pos_d  = head_q;
                            if (jump_q[head_q] != pred_q[head_q]) begin
                                rollback_d    = 1'b1;
                                rollback_pc_d = jump_q[head_q] ? target_q[head_q] : head_link;
                            end
                        end
                        default: begin
                            commit_d     = 1'b1;
                            commit_rd_d  = rd_q[head_q];
                            commit_val_d = val_q[head_q];
                            commit_pos_d = head_q;
                        end
                    endcase
                end
                if (rob.issue) begin
                    busy_d[tail_q]  = 1'b1;
                    ready_d[tail_q] = rob.issue_rdy;
                    type_d[tail_q]  = rob.issue_type;
                    rd_d[tail_q]    = rob.issue_rd;
                    val_d[tail_q]   = rob.issue_val;
                    pc_d[tail_q]    = rob.issue_pc;
                    pred_d[tail_q]  = rob.issue_pred_jump;
                    tail_d          = tail_q + ROB_W'(1);
                end
                case ({rob.issue, head_fire})
                    2'b10:   count_d = count_q + (ROB_W+1)'(1);
                    2'b01:   count_d = count_q - (ROB_W+1)'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                type_q[i]   <= 2'd0;
                rd_q[i]     <= 5'd0;
                val_q[i]    <= 32'd0;
                pc_q[i]     <= 32'd0;
                pred_q[i]   <= 1'b0;
                jump_q[i]   <= 1'b0;
                target_q[i] <= 32'd0;
            end
            commit_q       <= 1'b0;
            commit_rd_q    <= 5'd0;
            commit_val_q   <= 32'd0;
            commit_pos_q   <= '0;
            store_commit_q <= 1'b0;
            store_pos_q    <= '0;
            rollback_q     <= 1'b0;
            rollback_pc_q  <= 32'd0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            val_q          <= val_d;
            pc_q           <= pc_d;
            pred_q         <= pred_d;
            jump_q         <= jump_d;
            target_q       <= target_d;
            commit_q       <= commit_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_pos_q   <= commit_pos_d;
            store_commit_q <= store_commit_d;
            store_pos_q    <= store_pos_d;
            rollback_q     <= rollback_d;
            rollback_pc_q  <= rollback_pc_d;
        end
    end

    // Operand queries; the forwarding build lets a waiting consumer see this cycle's bus value.
    always_comb begin
        q1_rdy = busy_q[rob.q1_pos] && ready_q[rob.q1_pos];
        q1_val = val_q[rob.q1_pos];
        q2_rdy = busy_q[rob.q2_pos] && ready_q[rob.q2_pos];
        q2_val = val_q[rob.q2_pos];
`ifdef ROB_WB_FWD_EN
        if (rob.alu_valid && rob.alu_pos == rob.q1_pos) begin
            q1_rdy = 1'b1;
            q1_val = rob.alu_val;
        end else if (rob.lsb_valid && rob.lsb_pos == rob.q1_pos) begin
            q1_rdy = 1'b1;
            q1_val = rob.lsb_val;
        end
        if (rob.alu_valid && rob.alu_pos == rob.q2_pos) begin
            q2_rdy = 1'b1;
            q2_val = rob.alu_val;
        end else if (rob.lsb_valid && rob.lsb_pos == rob.q2_pos) begin
            q2_rdy = 1'b1;
            q2_val = rob.lsb_val;
        end
`endif
    end

    // Retire pulses are masked while the pipeline is stalled so no consumer acts on them.
    assign rob.full         = count_q >= (ROB_W+1)'(ROB_SIZE - 1);
    assign rob.tail_pos     = tail_q;
    assign rob.q1_rdy       = q1_rdy;
    assign rob.q1_val       = q1_val;
    assign rob.q2_rdy       = q2_rdy;
    assign rob.q2_val       = q2_val;
    assign rob.commit       = commit_q && rdy;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_val   = commit_val_q;
    assign rob.commit_pos   = commit_pos_q;
    assign rob.store_commit = store_commit_q && rdy;
    assign rob.store_pos    = store_pos_q;
    assign rob.rollback     = rollback_q && rdy;
    assign rob.rollback_pc  = rollback_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: reset, commit paths, wrap, rollback, store release,
// operand queries (both ROB_WB_FWD_EN builds) and the rdy stall.
module tb_reorder_buffer;
    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   checks = 0;
    int   errors = 0;
    int   occ = 0;

    reorder_buffer_if #(.ROB_W(4)) bus ();

    reorder_buffer #(.ROB_SIZE(16), .ROB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (bus)
    );

    always #5 clk = ~clk;

    // Occupancy estimate (never below the real count) used to flag an issue into a completely full buffer.
    always @(posedge clk) begin
        if (!rst) begin
            occ <= 0;
        end else if (rdy) begin
            if (bus.issue) begin
                checks++;
                if (occ >= 16) begin
                    errors++;
                    $display("[TB] FAIL protocol_overflow: occupancy %0d, required below 16", occ);
                end
            end
            if (bus.rollback) occ <= 0;
            else occ <= occ + (bus.issue ? 1 : 0) - ((bus.commit || bus.store_commit) ? 1 : 0);
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.issue = 1'b0; bus.issue_type = T_REG; bus.issue_rd = 5'd0; bus.issue_pc = 32'd0;
        bus.issue_pred_jump = 1'b0; bus.issue_rdy = 1'b0; bus.issue_val = 32'd0;
        bus.alu_valid = 1'b0; bus.alu_pos = 4'd0; bus.alu_val = 32'd0; bus.alu_jump = 1'b0;
        bus.alu_target = 32'd0; bus.lsb_valid = 1'b0; bus.lsb_pos = 4'd0; bus.lsb_val = 32'd0;
    endtask

    task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                               input logic pred, input logic irdy, input logic [31:0] ival);
        bus.issue = 1'b1; bus.issue_type = t; bus.issue_rd = rd; bus.issue_pc = pc;
        bus.issue_pred_jump = pred; bus.issue_rdy = irdy; bus.issue_val = ival;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.tail_pos !== 4'd0) begin errors++; $display("[TB] FAIL reset_tail: got %0d want 0", bus.tail_pos); end
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit: got %b want 0", bus.commit); end
        checks++; if (bus.rollback !== 1'b0) begin errors++; $display("[TB] FAIL reset_rollback: got %b want 0", bus.rollback); end
        checks++; if (bus.store_commit !== 1'b0) begin errors++; $display("[TB] FAIL reset_store: got %b want 0", bus.store_commit); end
        rst = 1'b1;
    endtask

    task automatic test_reg_commit();
        drive_issue(T_REG, 5'd5, 32'h0, 1'b0, 1'b0, 32'd0);
        step();
        checks++; if (bus.tail_pos !== 4'd1) begin errors++; $display("[TB] FAIL reg_tail: got %0d want 1", bus.tail_pos); end
        clear_inputs();
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd0; bus.alu_val = 32'h1234;
        step();
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL reg_early_commit: got %b want 0", bus.commit); end
        clear_inputs();
        step();
        checks++; if (bus.commit !== 1'b1) begin errors++; $display("[TB] FAIL reg_commit: got %b want 1", bus.commit); end
        checks++; if (bus.commit_rd !== 5'd5) begin errors++; $display("[TB] FAIL reg_rd: got %0d want 5", bus.commit_rd); end
        checks++; if (bus.commit_val !== 32'h1234) begin errors++; $display("[TB] FAIL reg_val: got %h want 1234", bus.commit_val); end
        checks++; if (bus.commit_pos !== 4'd0) begin errors++; $display("[TB] FAIL reg_pos: got %0d want 0", bus.commit_pos); end
        step();
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL reg_one_pulse: got %b want 0", bus.commit); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 15; i++) begin
            checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_early[%0d]: got %b want 0", i, bus.full); end
            checks++; if (bus.tail_pos !== 4'(i + 1)) begin errors++; $display("[TB] FAIL fill_tail[%0d]: got %0d want %0d", i, bus.tail_pos, i + 1); end
            drive_issue(T_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'd0);
            step();
        end
        clear_inputs();
        checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b want 1", bus.full); end
        checks++; if (bus.tail_pos !== 4'd0) begin errors++; $display("[TB] FAIL fill_tail_wrap: got %0d want 0", bus.tail_pos); end
        for (int k = 0; k < 16; k++) begin
            clear_inputs();
            if (k < 15) begin
                if (k % 2 == 0) begin
                    bus.alu_valid = 1'b1; bus.alu_pos = 4'(k + 1); bus.alu_val = 32'h100 + 32'(k);
                end else begin
                    bus.lsb_valid = 1'b1; bus.lsb_pos = 4'(k + 1); bus.lsb_val = 32'h100 + 32'(k);
                end
            end
            step();
            if (k >= 1) begin
                checks++; if (bus.commit !== 1'b1) begin errors++; $display("[TB] FAIL drain_commit[%0d]: got %b want 1", k, bus.commit); end
                checks++; if (bus.commit_pos !== 4'(k)) begin errors++; $display("[TB] FAIL drain_pos[%0d]: got %0d want %0d", k, bus.commit_pos, k); end
                checks++; if (bus.commit_rd !== 5'(k)) begin errors++; $display("[TB] FAIL drain_rd[%0d]: got %0d want %0d", k, bus.commit_rd, k); end
                checks++; if (bus.commit_val !== 32'h100 + 32'(k - 1)) begin errors++; $display("[TB] FAIL drain_val[%0d]: got %h want %h", k, bus.commit_val, 32'h100 + 32'(k - 1)); end
            end
        end
        clear_inputs();
        step();
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL drain_done: got %b want 0", bus.commit); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL drain_full: got %b want 0", bus.full); end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 5; j++) begin
            if (j < 4) drive_issue(T_REG, 5'(20 + j), 32'h2000, 1'b0, 1'b1, 32'hA000 + 32'(j));
            else clear_inputs();
            step();
            if (j == 0) begin
                checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL b2b_same_cycle: got %b want 0", bus.commit); end
            end else begin
                checks++; if (bus.commit !== 1'b1) begin errors++; $display("[TB] FAIL b2b_commit[%0d]: got %b want 1", j, bus.commit); end
                checks++; if (bus.commit_pos !== 4'(j - 1)) begin errors++; $display("[TB] FAIL b2b_pos[%0d]: got %0d want %0d", j, bus.commit_pos, j - 1); end
                checks++; if (bus.commit_val !== 32'hA000 + 32'(j - 1)) begin errors++; $display("[TB] FAIL b2b_val[%0d]: got %h want %h", j, bus.commit_val, 32'hA000 + 32'(j - 1)); end
            end
        end
        step();
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got %b want 0", bus.commit); end
        checks++; if (bus.tail_pos !== 4'd4) begin errors++; $display("[TB] FAIL b2b_tail: got %0d want 4", bus.tail_pos); end
    endtask

    task automatic test_branch_rollback();
        drive_issue(T_BRANCH, 5'd1, 32'h100, 1'b0, 1'b0, 32'd0);
        step();
        drive_issue(T_REG, 5'd2, 32'h104, 1'b0, 1'b1, 32'h55);
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd4; bus.alu_jump = 1'b1; bus.alu_target = 32'h200;
        step();
        clear_inputs();
        step();
        checks++; if (bus.commit !== 1'b1) begin errors++; $display("[TB] FAIL br_commit: got %b want 1", bus.commit); end
        checks++; if (bus.commit_pos !== 4'd4) begin errors++; $display("[TB] FAIL br_pos: got %0d want 4", bus.commit_pos); end
        checks++; if (bus.commit_val !== 32'h104) begin errors++; $display("[TB] FAIL br_link: got %h want 104", bus.commit_val); end
        checks++; if (bus.rollback !== 1'b1) begin errors++; $display("[TB] FAIL br_rollback: got %b want 1", bus.rollback); end
        checks++; if (bus.rollback_pc !== 32'h200) begin errors++; $display("[TB] FAIL br_rollback_pc: got %h want 200", bus.rollback_pc); end
        drive_issue(T_REG, 5'd3, 32'h300, 1'b0, 1'b1, 32'h77);
        step();
        clear_inputs();
        checks++; if (bus.rollback !== 1'b0) begin errors++; $display("[TB] FAIL br_rollback_pulse: got %b want 0", bus.rollback); end
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL br_flushed_commit: got %b want 0", bus.commit); end
        checks++; if (bus.tail_pos !== 4'd0) begin errors++; $display("[TB] FAIL br_tail_clear: got %0d want 0", bus.tail_pos); end
        step();
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL br_dropped_issue: got %b want 0", bus.commit); end
        checks++; if (bus.tail_pos !== 4'd0) begin errors++; $display("[TB] FAIL br_tail_hold: got %0d want 0", bus.tail_pos); end
        // Correctly predicted taken branch, then a predicted-taken branch that falls through.
        drive_issue(T_BRANCH, 5'd6, 32'h80, 1'b1, 1'b0, 32'd0);
        step();
        drive_issue(T_BRANCH, 5'd7, 32'h40, 1'b1, 1'b0, 32'd0);
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd0; bus.alu_jump = 1'b1; bus.alu_target = 32'h90;
        step();
        clear_inputs();
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd1; bus.alu_jump = 1'b0; bus.alu_target = 32'h999;
        step();
        clear_inputs();
        checks++; if (bus.commit !== 1'b1 || bus.commit_val !== 32'h84) begin errors++; $display("[TB] FAIL br_ok_commit: got %b/%h want 1/84", bus.commit, bus.commit_val); end
        checks++; if (bus.rollback !== 1'b0) begin errors++; $display("[TB] FAIL br_ok_rollback: got %b want 0", bus.rollback); end
        step();
        checks++; if (bus.commit_pos !== 4'd1 || bus.commit_val !== 32'h44) begin errors++; $display("[TB] FAIL br_nt_commit: got %0d/%h want 1/44", bus.commit_pos, bus.commit_val); end
        checks++; if (bus.rollback !== 1'b1) begin errors++; $display("[TB] FAIL br_nt_rollback: got %b want 1", bus.rollback); end
        checks++; if (bus.rollback_pc !== 32'h44) begin errors++; $display("[TB] FAIL br_nt_pc: got %h want 44", bus.rollback_pc); end
        step();
        checks++; if (bus.tail_pos !== 4'd0) begin errors++; $display("[TB] FAIL br_nt_tail: got %0d want 0", bus.tail_pos); end
    endtask

    task automatic test_store();
        for (int j = 0; j < 3; j++) begin
            drive_issue(T_REG, 5'(10 + j), 32'h3000, 1'b0, 1'b1, 32'hB0 + 32'(j));
            step();
        end
        drive_issue(T_STORE, 5'd0, 32'h300C, 1'b0, 1'b0, 32'd0);
        step();
        checks++; if (bus.commit_pos !== 4'd2 || bus.commit !== 1'b1) begin errors++; $display("[TB] FAIL st_prev_commit: got %b/%0d want 1/2", bus.commit, bus.commit_pos); end
        clear_inputs();
        bus.lsb_valid = 1'b1; bus.lsb_pos = 4'd3; bus.lsb_val = 32'd0;
        step();
        clear_inputs();
        checks++; if (bus.store_commit !== 1'b0) begin errors++; $display("[TB] FAIL st_early: got %b want 0", bus.store_commit); end
        step();
        checks++; if (bus.store_commit !== 1'b1) begin errors++; $display("[TB] FAIL st_commit: got %b want 1", bus.store_commit); end
        checks++; if (bus.store_pos !== 4'd3) begin errors++; $display("[TB] FAIL st_pos: got %0d want 3", bus.store_pos); end
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL st_no_reg_commit: got %b want 0", bus.commit); end
        step();
        checks++; if (bus.store_commit !== 1'b0) begin errors++; $display("[TB] FAIL st_one_pulse: got %b want 0", bus.store_commit); end
    endtask

    task automatic test_query();
        logic exp_fwd;
`ifdef ROB_WB_FWD_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive_issue(T_REG, 5'(j + 1), 32'h4000, 1'b0, 1'b0, 32'd0);
            step();
        end
        clear_inputs();
        bus.q1_pos = 4'd2; bus.q2_pos = 4'd1;
        #1;
        checks++; if (bus.q1_rdy !== 1'b0 || bus.q2_rdy !== 1'b0) begin errors++; $display("[TB] FAIL q_idle: got %b/%b want 0/0", bus.q1_rdy, bus.q2_rdy); end
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd2; bus.alu_val = 32'd7;
        bus.lsb_valid = 1'b1; bus.lsb_pos = 4'd1; bus.lsb_val = 32'd9;
        #1;
        checks++; if (bus.q1_rdy !== exp_fwd) begin errors++; $display("[TB] FAIL q1_fwd_rdy: got %b want %b", bus.q1_rdy, exp_fwd); end
        checks++; if (bus.q2_rdy !== exp_fwd) begin errors++; $display("[TB] FAIL q2_fwd_rdy: got %b want %b", bus.q2_rdy, exp_fwd); end
`ifdef ROB_WB_FWD_EN
        checks++; if (bus.q1_val !== 32'd7 || bus.q2_val !== 32'd9) begin errors++; $display("[TB] FAIL q_fwd_val: got %0d/%0d want 7/9", bus.q1_val, bus.q2_val); end
`endif
        step();
        clear_inputs();
        #1;
        checks++; if (bus.q1_rdy !== 1'b1 || bus.q1_val !== 32'd7) begin errors++; $display("[TB] FAIL q1_reg: got %b/%0d want 1/7", bus.q1_rdy, bus.q1_val); end
        checks++; if (bus.q2_rdy !== 1'b1 || bus.q2_val !== 32'd9) begin errors++; $display("[TB] FAIL q2_reg: got %b/%0d want 1/9", bus.q2_rdy, bus.q2_val); end
        bus.q2_pos = 4'd5;
        #1;
        checks++; if (bus.q2_rdy !== 1'b0) begin errors++; $display("[TB] FAIL q2_free_slot: got %b want 0", bus.q2_rdy); end
    endtask

    task automatic test_rdy_hold();
        rdy = 1'b0;
        drive_issue(T_REG, 5'd9, 32'h5000, 1'b0, 1'b1, 32'h11);
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd0; bus.alu_val = 32'hAB;
        step();
        clear_inputs();
        bus.q1_pos = 4'd0;
        #1;
        checks++; if (bus.q1_rdy !== 1'b0) begin errors++; $display("[TB] FAIL hold_wb: got %b want 0", bus.q1_rdy); end
        checks++; if (bus.tail_pos !== 4'd3) begin errors++; $display("[TB] FAIL hold_tail: got %0d want 3", bus.tail_pos); end
        rdy = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_pos = 4'd0; bus.alu_val = 32'hAB;
        step();
        clear_inputs();
        step();
        checks++; if (bus.commit !== 1'b1 || bus.commit_pos !== 4'd0 || bus.commit_val !== 32'hAB) begin errors++; $display("[TB] FAIL hold_commit0: got %b/%0d/%h want 1/0/ab", bus.commit, bus.commit_pos, bus.commit_val); end
        rdy = 1'b0;
        #1;
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL hold_forced_low: got %b want 0", bus.commit); end
        rdy = 1'b1;
        step();
        checks++; if (bus.commit !== 1'b1 || bus.commit_pos !== 4'd1 || bus.commit_val !== 32'd9) begin errors++; $display("[TB] FAIL hold_commit1: got %b/%0d/%0d want 1/1/9", bus.commit, bus.commit_pos, bus.commit_val); end
        step();
        checks++; if (bus.commit_pos !== 4'd2 || bus.commit_val !== 32'd7) begin errors++; $display("[TB] FAIL hold_commit2: got %0d/%0d want 2/7", bus.commit_pos, bus.commit_val); end
        step();
        checks++; if (bus.commit !== 1'b0) begin errors++; $display("[TB] FAIL hold_empty: got %b want 0", bus.commit); end
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        bus.q1_pos = 4'd0;
        bus.q2_pos = 4'd0;
        clear_inputs();
        test_reset();
        test_reg_commit();
        test_fill_wrap();
        test_back_to_back();
        test_branch_rollback();
        test_store();
        test_query();
        test_rdy_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between Decoder/RS/LSB and RegFile.
- Allocates one entry per issued instruction and captures results from two writeback buses.
- Retires at most one ready head entry per cycle: register write to RegFile, store release to LSB.
- Detects branch misprediction at commit and drives the global rollback and redirect PC.

Parameters:
ROB_SIZE, 16, number of entries; power of two
ROB_W, 4, log2(ROB_SIZE); width of every rob_pos field

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
rdy  in  1  global enable; when low, all state holds
full  out  1  no free slot for the decoder
issue  in  1  allocate an entry at the tail this cycle
issue_type  in  2  0 REG, 1 STORE, 2 BRANCH
issue_rd  in  5  destination register
issue_pc  in  32  instruction PC
issue_pred_jump  in  1  predictor decision for BRANCH
issue_rdy  in  1  entry is complete at issue (e.g. LUI)
issue_val  in  32  value used when issue_rdy=1
tail_pos  out  ROB_W  position the next issue receives
alu_valid  in  1  ALU result bus valid
alu_pos  in  ROB_W  ALU result target entry
alu_val  in  32  ALU result value
alu_jump  in  1  actual branch outcome
alu_target  in  32  actual next PC for BRANCH
lsb_valid  in  1  LSB result bus valid
lsb_pos  in  ROB_W  LSB result target entry
lsb_val  in  32  LSB result value
q1_pos, q2_pos  in  ROB_W  decoder operand queries
q1_rdy, q2_rdy  out  1  queried entry is ready
q1_val, q2_val  out  32  queried entry value
commit  out  1  register commit pulse to RegFile
commit_rd  out  5  destination register
commit_val  out  32  committed value
commit_pos  out  ROB_W  committed entry position (head)
store_commit  out  1  release head store to LSB
store_pos  out  ROB_W  position of the released store
rollback  out  1  flush pulse to all units
rollback_pc  out  32  redirect PC

Behaviour:
- State: head, tail (ROB_W bits each, wrap modulo ROB_SIZE); count (ROB_W+1 bits); per entry busy, ready, type, rd, val, pc, pred_jump, jump, target.
- Reset (rst=0 at posedge): head=tail=count=0; all busy/ready cleared. Outputs reset to 0: commit, store_commit, rollback, commit_*, store_pos, rollback_pc. full=0.
- full is combinational: count >= ROB_SIZE-1. The one-slot slack absorbs the decoder's one-cycle reaction. Issue at count==ROB_SIZE is a protocol violation; bench asserts it never occurs.
- Issue (issue && rdy): entry[tail] written at the posedge; tail+1; count+1. ready=issue_rdy, val=issue_val. tail_pos=tail, combinational.
- Writeback: alu_valid/lsb_valid set ready and val of the target entry. ALU bus also latches jump and target. Both buses to distinct entries in the same cycle are legal. Same entry is illegal.
- Commit: evaluated on registered state each cycle. When entry[head] is busy && ready, the outputs below are registered and valid the next cycle for exactly one cycle; head+1, count-1, busy cleared.
  - REG: commit=1, commit_rd=rd, commit_val=val, commit_pos=head. rd=0 is still committed; RegFile ignores x0.
  - STORE: store_commit=1, store_pos=head.
  - BRANCH: commit=1 with val=pc+4 (link value). If jump != pred_jump: rollback=1, rollback_pc = jump ? target : pc+4.
- Writeback and commit of the same entry in the same cycle: the entry is not ready yet and commits no earlier than the next cycle.
- Issue and commit in the same cycle: count unchanged. Empty buffer with issue_rdy=1: earliest commit is the cycle after issue.
- Rollback: in the cycle rollback is asserted, the buffer clears: head=tail=count=0, all busy=0. Issue and writeback are ignored in that cycle (rollback has priority). No further commits until new issues.
- rdy=0: no state change; commit/store_commit/rollback are forced to 0 while low.
- Query: q*_rdy = busy && ready of entry[q*_pos]; q*_val = val; combinational.

Optional Feature:
ROB_WB_FWD_EN:
- Defined: if alu_valid && alu_pos==q*_pos, or lsb_valid && lsb_pos==q*_pos, the query returns rdy=1 and the bus value in the same cycle. ALU takes precedence.
- Undefined: a query reflects registered state only, so forwarding is visible one cycle later.

Test Plan:
- Reset with rst=0 for 2 cycles -> full=0, tail_pos=0, commit=0, rollback=0.
- Issue REG rd=5 at pos 0, alu_valid pos 0 val 0x1234 -> next cycle commit=1, commit_rd=5, commit_val=0x1234, commit_pos=0.
- Issue 15 entries with no writeback -> full=1 at count 15; writeback all in order -> 15 consecutive commits, head wraps 15->0.
- BRANCH at pc 0x100, pred_jump=0, alu_jump=1, target 0x200 -> rollback=1 for one cycle, rollback_pc=0x200, tail_pos=0 the cycle after; an issue during rollback is dropped.
- STORE at pos 3 made ready -> store_commit=1, store_pos=3, commit=0.
- Query q1_pos=2 while alu_valid pos 2 val 7 -> with ROB_WB_FWD_EN q1_rdy=1, q1_val=7 same cycle; without it q1_rdy=0, becoming 1 the next cycle.
